seg_scan_mux: RTL and testbench
===============================

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter DIV, default 50000: clock cycles per digit slot; legal values DIV >= 4.
REQ-002 SHALL have parameter BLANK, default 500: cycles blanked at the start of each slot; legal values 1 <= BLANK < DIV.
REQ-003 SHALL have port clk  input  1  the single clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port value  input  16  four hex digits; digit0 = value[3:0], digit3 = value[15:12].
REQ-006 SHALL have port load  input  1  when high at a clk edge, capture value into the pending register.
REQ-007 SHALL have port lzb  input  1  enables leading-zero blanking.
REQ-008 SHALL have port nibble  output  4  current digit code; drives seven_seg in.
REQ-009 SHALL have port seg_en  output  1  drives seven_seg enable.
REQ-010 SHALL have port anode  output  4  active-low one-hot digit select; bit i selects digit i.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at the start of each frame.
REQ-012 SHALL have port pending  output  1  high while a captured value waits for a frame boundary.

Function
REQ-013 SHALL keep a slot counter cnt (0..DIV-1), incremented every cycle and wrapping DIV-1 -> 0.
REQ-014 SHALL keep a digit index idx (0..3), incremented when cnt wraps, with 3 -> 0 wrap-around.
REQ-015 SHALL run a two-state FSM: BLANK while cnt < BLANK, SHOW while cnt >= BLANK; BLANK -> SHOW at cnt == BLANK and SHOW -> BLANK at the cnt wrap.
REQ-016 SHALL, in BLANK, drive anode = 4'b1111 and seg_en = 0.
REQ-017 SHALL, in SHOW, drive anode[idx] = 0 with other bits 1 and seg_en = 1, unless digit idx is suppressed (REQ-020).
REQ-018 SHALL drive nibble = disp[4*idx+3 : 4*idx] in both states, where disp is the 16-bit display register.
REQ-019 SHALL make all outputs Moore functions of registered state, with no combinational path from any input to any output.
REQ-020 SHALL treat digit i (i = 1..3) as suppressed when lzb = 1 and disp nibbles i..3 are all zero; a suppressed digit drives anode = 4'b1111 and seg_en = 0 for its whole slot, and digit0 is never suppressed.
REQ-021 SHALL, on load = 1, set pend <= value and pending <= 1.
REQ-022 SHALL define the frame boundary as the edge where cnt == DIV-1 and idx == 3; at that edge, if pending = 1 then disp <= pend and pending <= 0.
REQ-023 SHALL, when load coincides with a frame boundary, first transfer the old pend to disp (if pending was 1), then set pend <= value with pending remaining 1.
REQ-024 SHALL ensure disp never changes other than at a frame boundary (no tearing mid-frame).
REQ-025 SHALL register frame_done so it is high only in the cycle where cnt == 0 and idx == 0, excluding the first cycle after reset release.
REQ-026 SHALL have a frame period of exactly 4*DIV cycles.

Reset
REQ-027 SHALL, while rst is high and immediately regardless of clk, force cnt = 0, idx = 0, state = BLANK, disp = 0, pend = 0, pending = 0, anode = 4'b1111, seg_en = 0, nibble = 0, frame_done = 0.
REQ-028 SHALL treat reset asserted mid-slot or mid-frame as aborting the slot, discarding pend, and restarting at digit0 BLANK after release.

Verification (DIV=8, BLANK=2)
REQ-029 Release rst, lzb=0 -> cycles 0-1: anode=1111, seg_en=0; cycles 2-7: anode=1110, seg_en=1, nibble=0; cycle 10: anode=1101.
REQ-030 load with value=16'h1234 at cycle 5 -> pending=1 and digit0 still shows 0 until cycle 32; at cycle 32 pending=0; SHOW slots then give nibble 4, 3, 2, 1 on anode 1110, 1101, 1011, 0111.
REQ-031 lzb=1 with disp=16'h0050 -> digit3 and digit2 slots: anode=1111, seg_en=0; digit1: nibble=5; digit0: nibble=0, seg_en=1; with disp=0, only digit0 lights, showing 0.
REQ-032 Free-run 128 cycles -> frame_done high exactly at cycles 32, 64, 96, 128, one cycle wide each.
REQ-033 Assert rst during SHOW of digit2 -> anode=1111 and seg_en=0 before the next clk edge; after release, idx=0 and the frame restarts with pending=0.
REQ-034 load value=16'hABCD at a boundary while pend holds 16'h1111 with pending=1 -> next frame shows 1111, pending stays 1, and the following frame shows ABCD.

Source files
------------

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - four-digit multiplexed seven-segment scanner with blanking and frame-synchronous updates
module seg_scan_mux #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        lzb,
    output logic [3:0]  nibble,
    output logic        seg_en,
    output logic [3:0]  anode,
    output logic        frame_done,
    output logic        pending
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_M1 = CW'(BLANK - 1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   disp;
    logic [15:0]   pend;
    logic          lzb_q;
    logic          suppress;
    logic          boundary;

    assign boundary = (cnt == CNT_MAX) && (idx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BLANK;
        end else begin
            state <= state_nx;
        end
    end

    // State changes one edge early so the registered state matches cnt in the same cycle.
    always_comb begin
        state_nx = state;
        if (cnt == CNT_MAX) begin
            state_nx = ST_BLANK;
        end else if (cnt == BLANK_M1) begin
            state_nx = ST_SHOW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            disp       <= 16'h0000;
            pend       <= 16'h0000;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            lzb_q      <= 1'b0;
        end else begin
            cnt        <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            lzb_q      <= lzb;
            frame_done <= boundary;
            if (cnt == CNT_MAX) begin
                idx <= idx + 2'd1;
            end
            if (boundary && pending) begin
                disp    <= pend;
                pending <= 1'b0;
            end
            // A coinciding load wins over the boundary clear: the new value waits a full frame.
            if (load) begin
                pend    <= value;
                pending <= 1'b1;
            end
        end
    end

    // lzb is registered so outputs depend only on flop state.
    always_comb begin
        suppress = 1'b0;
        case (idx)
            2'd1:    suppress = lzb_q && (disp[15:4] == 12'h000);
            2'd2:    suppress = lzb_q && (disp[15:8] == 8'h00);
            2'd3:    suppress = lzb_q && (disp[15:12] == 4'h0);
            default: suppress = 1'b0;
        endcase
    end

    always_comb begin
        anode  = 4'b1111;
        seg_en = 1'b0;
        nibble = disp[{idx, 2'b00} +: 4];
        if (state == ST_SHOW && !suppress) begin
            anode  = ~(4'b0001 << idx);
            seg_en = 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - self-checking bench for seg_scan_mux against a cycle-count reference model
module tb_seg_scan_mux;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        lzb;
    logic [3:0]  nibble;
    logic        seg_en;
    logic [3:0]  anode;
    logic        frame_done;
    logic        pending;

    int checks   = 0;
    int failures = 0;

    int          t;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_pending;
    logic        m_fd;
    logic        m_lzb;

    logic [10:0] obs;
    assign obs = {anode, seg_en, nibble, frame_done, pending};

    seg_scan_mux #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .lzb        (lzb),
        .nibble     (nibble),
        .seg_en     (seg_en),
        .anode      (anode),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] expected();
        int          c;
        int          i;
        logic [3:0]  nib;
        logic [3:0]  one;
        logic [3:0]  an;
        logic        supp;
        logic        show;
        c    = t % DIV;
        i    = (t / DIV) % 4;
        nib  = m_disp[4*i +: 4];
        supp = (i != 0) && m_lzb && ((m_disp >> (4 * i)) == 16'h0000);
        show = (c >= BLANK) && !supp;
        one  = 4'b0001;
        an   = show ? ~(one << i) : 4'b1111;
        return {an, show, nib, m_fd, m_pending};
    endfunction

    task automatic model_reset();
        t         = 0;
        m_disp    = 16'h0000;
        m_pend    = 16'h0000;
        m_pending = 1'b0;
        m_fd      = 1'b0;
        m_lzb     = 1'b0;
    endtask

    task automatic model_step();
        logic bnd;
        bnd = (t % DIV == DIV - 1) && ((t / DIV) % 4 == 3);
        if (bnd && m_pending) begin
            m_disp    = m_pend;
            m_pending = 1'b0;
        end
        if (load) begin
            m_pend    = value;
            m_pending = 1'b1;
        end
        m_fd  = bnd;
        m_lzb = lzb;
        t++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        load  = 1'b0;
        lzb   = 1'b0;
        value = 16'h0000;
        #12;
        checks++;
        if (obs !== 11'b1111_0_0000_0_0) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", obs, 11'b1111_0_0000_0_0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if (obs !== expected()) begin
            failures++;
            $display("FAIL reset_cycle0 got=%b exp=%b", obs, expected());
        end
    endtask

    task automatic test_scan();
        do_reset();
        lzb = 1'b0;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (obs !== expected()) begin
                failures++;
                $display("FAIL scan cyc=%0d got=%b exp=%b", k, obs, expected());
            end
            if (k == 10) begin
                checks++;
                if (anode !== 4'b1101) begin
                    failures++;
                    $display("FAIL scan_digit1 got=%b exp=%b", anode, 4'b1101);
                end
            end
            tick();
        end
    endtask

    task automatic test_load();
        logic [3:0] exp_nib;
        logic [3:0] exp_an;
        do_reset();
        value = 16'h1234;
        for (int k = 0; k < 76; k++) begin
            checks++;
            if (obs !== expected()) begin
                failures++;
                $display("FAIL load cyc=%0d got=%b exp=%b", k, obs, expected());
            end
            if (k == 26 || k == 31) begin
                checks++;
                if ({pending, nibble} !== 5'b1_0000) begin
                    failures++;
                    $display("FAIL load_wait cyc=%0d got=%b exp=%b", k, {pending, nibble}, 5'b1_0000);
                end
            end
            if (k == 32) begin
                checks++;
                if (pending !== 1'b0) begin
                    failures++;
                    $display("FAIL load_boundary got=%b exp=%b", pending, 1'b0);
                end
            end
            if (k == 34 || k == 42 || k == 50 || k == 58) begin
                case (k)
                    34:      begin exp_nib = 4'h4; exp_an = 4'b1110; end
                    42:      begin exp_nib = 4'h3; exp_an = 4'b1101; end
                    50:      begin exp_nib = 4'h2; exp_an = 4'b1011; end
                    default: begin exp_nib = 4'h1; exp_an = 4'b0111; end
                endcase
                checks++;
                if ({anode, nibble} !== {exp_an, exp_nib}) begin
                    failures++;
                    $display("FAIL load_show cyc=%0d got=%h exp=%h", k, {anode, nibble}, {exp_an, exp_nib});
                end
            end
            load = (k == 5);
            tick();
        end
        load = 1'b0;
    endtask

    task automatic test_lzb();
        do_reset();
        lzb = 1'b1;
        for (int k = 0; k < 96; k++) begin
            checks++;
            if (obs !== expected()) begin
                failures++;
                $display("FAIL lzb cyc=%0d got=%b exp=%b", k, obs, expected());
            end
            if (k == 58 || k == 50 || k == 74 || k == 82 || k == 90) begin
                checks++;
                if ({anode, seg_en} !== 5'b1111_0) begin
                    failures++;
                    $display("FAIL lzb_suppress cyc=%0d got=%b exp=%b", k, {anode, seg_en}, 5'b1111_0);
                end
            end
            if (k == 42) begin
                checks++;
                if ({anode, seg_en, nibble} !== {4'b1101, 1'b1, 4'h5}) begin
                    failures++;
                    $display("FAIL lzb_digit1 got=%b exp=%b", {anode, seg_en, nibble}, {4'b1101, 1'b1, 4'h5});
                end
            end
            if (k == 34 || k == 66) begin
                checks++;
                if ({anode, seg_en, nibble} !== {4'b1110, 1'b1, 4'h0}) begin
                    failures++;
                    $display("FAIL lzb_digit0 cyc=%0d got=%b exp=%b", k, {anode, seg_en, nibble}, {4'b1110, 1'b1, 4'h0});
                end
            end
            load  = (k == 0) || (k == 40);
            value = (k == 0) ? 16'h0050 : 16'h0000;
            tick();
        end
        load = 1'b0;
        lzb  = 1'b0;
    endtask

    task automatic test_frame_done();
        int pulses;
        pulses = 0;
        do_reset();
        for (int k = 0; k <= 128; k++) begin
            checks++;
            if (obs !== expected()) begin
                failures++;
                $display("FAIL frame cyc=%0d got=%b exp=%b", k, obs, expected());
            end
            checks++;
            if (frame_done !== (k > 0 && k % FRAME == 0)) begin
                failures++;
                $display("FAIL frame_done cyc=%0d got=%b exp=%b", k, frame_done, (k > 0 && k % FRAME == 0));
            end
            if (frame_done === 1'b1)
                pulses++;
            if (k < 128)
                tick();
        end
        checks++;
        if (pulses !== 4) begin
            failures++;
            $display("FAIL frame_pulses got=%0d exp=%0d", pulses, 4);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 128; k++) begin
            checks++;
            if (obs !== expected()) begin
                failures++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", k, obs, expected());
            end
            if (k == 66 || k == 90) begin
                checks++;
                if ({nibble, pending} !== {4'h1, 1'b1}) begin
                    failures++;
                    $display("FAIL b2b_old cyc=%0d got=%b exp=%b", k, {nibble, pending}, {4'h1, 1'b1});
                end
            end
            if (k == 98 || k == 122) begin
                checks++;
                if (nibble !== ((k == 98) ? 4'hD : 4'hA)) begin
                    failures++;
                    $display("FAIL b2b_new cyc=%0d got=%h exp=%h", k, nibble, (k == 98) ? 4'hD : 4'hA);
                end
            end
            load  = (k == 40) || (k == 63);
            value = (k == 40) ? 16'h1111 : 16'hABCD;
            tick();
        end
        load = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] mask;
        do_reset();
        for (int k = 0; k < 800; k++) begin
            checks++;
            if (obs !== expected()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", k, obs, expected());
            end
            case ($urandom_range(0, 3))
                0:       mask = 16'h000F;
                1:       mask = 16'h00FF;
                2:       mask = 16'h0FFF;
                default: mask = 16'hFFFF;
            endcase
            value = 16'($urandom) & mask;
            load  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0)
                lzb = ~lzb;
            tick();
        end
        load = 1'b0;
        lzb  = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 52; k++) begin
            load  = (k == 3) || (k == 40);
            value = (k == 3) ? 16'h4321 : 16'h9999;
            tick();
        end
        load = 1'b0;
        checks++;
        if ({anode, seg_en, pending} !== {4'b1011, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL mid_before got=%b exp=%b", {anode, seg_en, pending}, {4'b1011, 1'b1, 1'b1});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({anode, seg_en, pending, nibble} !== {4'b1111, 1'b0, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL mid_async got=%b exp=%b", {anode, seg_en, pending, nibble}, {4'b1111, 1'b0, 1'b0, 4'h0});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (obs !== expected()) begin
                failures++;
                $display("FAIL mid_after cyc=%0d got=%b exp=%b", k, obs, expected());
            end
            if (k == 2) begin
                checks++;
                if ({anode, nibble, pending} !== {4'b1110, 4'h0, 1'b0}) begin
                    failures++;
                    $display("FAIL mid_restart got=%b exp=%b", {anode, nibble, pending}, {4'b1110, 4'h0, 1'b0});
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_lzb();
        test_frame_done();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
